fetch_unit: RTL

Instruction-fetch stage that owns the program counter and acts on the branch decision (`PCSrc`, branch target) produced by the memory stage. Each cycle it drives a word address to the synchronous instruction memory, captures the returned word into the IF/ID output register, and either advances, holds (hazard stall), redirects (taken branch, with squash of the wrong-path word) or freezes on HALT. It sits between the instruction memory and the decode stage of the 16-bit pipeline.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_pc_reg.sv | 29 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the 16-bit pipeline instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;

    localparam logic [XLEN-1:0] NOP             = 16'h0000;
    localparam logic [3:0]      HALT_OP_DEFAULT = 4'hF;

    // What the fetch stage does on the coming clock edge.
    typedef enum logic [1:0] {
        ActReset,
        ActRedirect,
        ActHold,
        ActAdvance
    } fetch_act_e;

    function automatic logic [3:0] opcode_of(input logic [XLEN-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: synchronous reset, branch load, hold, or word increment (wraps mod 2^16).
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_hold,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (!i_hold) begin
            r_pc <= r_pc + XLEN'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC to synchronous instruction memory and fills
// the IF/ID register, handling stall, branch redirect with squash, and HALT freeze.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
    parameter logic [3:0]      HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_pc_src,
    input  logic [XLEN-1:0] i_branch_addr,
    output logic [XLEN-1:0] o_im_addr,
    output logic            o_im_rd,
    input  logic [XLEN-1:0] i_im_data,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc_plus1,
    output logic            o_valid,
    output logic            o_halted
);

    fetch_act_e      w_act;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_fetch_word;
    logic            w_halt_hit;
    logic            w_pc_load;
    logic            w_pc_hold;

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_fetch_valid;
    logic [XLEN-1:0] r_skid_data;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_plus1;
    logic            r_valid;
    logic            r_halted;

    always_comb begin
        w_act = ActAdvance;
        if (i_rst) begin
            w_act = ActReset;
        end else if (i_pc_src) begin
            w_act = ActRedirect;
        end else if (r_halted || i_stall) begin
            w_act = ActHold;
        end
    end

    // While stalled the memory re-reads the held PC, so the word for fetch_pc that
    // arrived on the first stall edge is parked here until the stall releases.
    assign w_fetch_word = r_skid_valid ? r_skid_data : i_im_data;

    assign w_halt_hit = (w_act == ActAdvance) && r_fetch_valid
                        && (opcode_of(w_fetch_word) == HALT_OP);
    assign w_pc_load  = (w_act == ActRedirect);
    assign w_pc_hold  = (w_act == ActHold) || w_halt_hit;

    fetch_unit_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_pc_load),
        .i_load_pc(i_branch_addr),
        .i_hold   (w_pc_hold),
        .o_pc     (w_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_skid_data   <= NOP;
            r_skid_valid  <= 1'b0;
            r_instr       <= NOP;
            r_pc_plus1    <= '0;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            unique case (w_act)
                ActRedirect: begin
                    r_fetch_pc    <= w_pc;
                    r_fetch_valid <= 1'b0;
                    r_skid_valid  <= 1'b0;
                    r_instr       <= NOP;
                    r_pc_plus1    <= '0;
                    r_valid       <= 1'b0;
                    r_halted      <= 1'b0;
                end
                ActHold: begin
                    if (!r_halted && !r_skid_valid) begin
                        r_skid_data  <= i_im_data;
                        r_skid_valid <= 1'b1;
                    end
                end
                ActAdvance: begin
                    r_instr      <= w_fetch_word;
                    r_pc_plus1   <= r_fetch_pc + XLEN'(1);
                    r_valid      <= r_fetch_valid;
                    r_skid_valid <= 1'b0;
                    r_halted     <= w_halt_hit;
                    if (!w_halt_hit) begin
                        r_fetch_pc    <= w_pc;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_im_addr  = w_pc;
    assign o_im_rd    = ~i_rst & ~r_halted;
    assign o_instr    = r_instr;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;
    assign o_halted   = r_halted;

endmodule
